// File: rtl/rom_access_controller.sv
// ============================================================================
// Module      : rom_access_controller
// Description : Sequences setup/access/hold read cycles on the shared ROM
//               socket for IP3601 (256x4) and IP3604 (512x8) chips.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_access_controller #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int ACCESS_CYCLES = 8,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     selected_chip,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] chip_address_port,
    output logic [3:0]               chip_selection_port,
    input  logic [DATA_WIDTH-1:0]    chip_data_port
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int C_MAX_SA     = (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
    localparam int C_MAX_CYCLES = (C_MAX_SA > HOLD_CYCLES) ? C_MAX_SA : HOLD_CYCLES;
    localparam int CNT_W        = (C_MAX_CYCLES + 1 > 2) ? $clog2(C_MAX_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] C_SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

    localparam logic [3:0] C_SEL_IDLE   = 4'b1111;
    localparam logic [3:0] C_SEL_IP3601 = 4'b1110;
    localparam logic [3:0] C_SEL_IP3604 = 4'b1101;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_count;
    logic                     r_chip;
    logic [ADDRESS_WIDTH-1:0] w_masked_addr;
    logic [DATA_WIDTH-1:0]    w_masked_data;

    // IP3601 decodes 8 address bits, IP3604 decodes 9; everything above is 0.
    always_comb begin
        w_masked_addr = '0;
        for (int i = 0; i < ADDRESS_WIDTH; i++) begin
            w_masked_addr[i] = (i < 8 || (selected_chip && i == 8)) ? req_address[i] : 1'b0;
        end
    end

    // IP3601 is a nibble-wide part; its upper data lines are not driven.
    always_comb begin
        w_masked_data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_masked_data[i] = (r_chip || i < 4) ? chip_data_port[i] : 1'b0;
        end
    end

    assign req_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state             <= IDLE;
            r_count             <= '0;
            r_chip              <= 1'b0;
            chip_address_port   <= '0;
            chip_selection_port <= C_SEL_IDLE;
            rsp_valid           <= 1'b0;
            rsp_data            <= '0;
            busy                <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state           <= SETUP;
                        r_count           <= C_SETUP_LOAD;
                        r_chip            <= selected_chip;
                        chip_address_port <= w_masked_addr;
                        busy              <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_count == '0) begin
                        r_state             <= ACCESS;
                        r_count             <= C_ACCESS_LOAD;
                        chip_selection_port <= r_chip ? C_SEL_IP3604 : C_SEL_IP3601;
                    end else begin
                        r_count <= r_count - C_CNT_ONE;
                    end
                end
                ACCESS: begin
                    if (r_count == '0) begin
                        r_state             <= HOLD;
                        r_count             <= C_HOLD_LOAD;
                        chip_selection_port <= C_SEL_IDLE;
                        rsp_valid           <= 1'b1;
                        rsp_data            <= w_masked_data;
                    end else begin
                        r_count <= r_count - C_CNT_ONE;
                    end
                end
                HOLD: begin
                    if (r_count == '0) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        busy    <= 1'b0;
                    end else begin
                        r_count <= r_count - C_CNT_ONE;
                    end
                end
                default: begin
                    r_state             <= IDLE;
                    r_count             <= '0;
                    chip_selection_port <= C_SEL_IDLE;
                    busy                <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_access_controller.sv
// ============================================================================
// Module      : tb_rom_access_controller
// Description : Directed bench with a time-since-acceptance reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_access_controller;

    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic check_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic          rv  [2];
    logic          sc  [2];
    logic [AW-1:0] ra  [2];
    logic [DW-1:0] cd  [2];
    logic          rdy [2];
    logic          rsv [2];
    logic          bsy [2];
    logic [DW-1:0] rd  [2];
    logic [AW-1:0] ca  [2];
    logic [3:0]    cs  [2];

    always #5 clk = ~clk;

    rom_access_controller #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .SETUP_CYCLES(2), .ACCESS_CYCLES(8), .HOLD_CYCLES(1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .selected_chip(sc[0]),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_address(ra[0]),
        .rsp_valid(rsv[0]), .rsp_data(rd[0]), .busy(bsy[0]),
        .chip_address_port(ca[0]), .chip_selection_port(cs[0]),
        .chip_data_port(cd[0])
    );

    rom_access_controller #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .SETUP_CYCLES(1), .ACCESS_CYCLES(1), .HOLD_CYCLES(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .selected_chip(sc[1]),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_address(ra[1]),
        .rsp_valid(rsv[1]), .rsp_data(rd[1]), .busy(bsy[1]),
        .chip_address_port(ca[1]), .chip_selection_port(cs[1]),
        .chip_data_port(cd[1])
    );

    function automatic int s_of(input int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int a_of(input int k); return (k == 0) ? 8 : 1; endfunction
    function automatic int h_of(input int k); return 1; endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] actual=%0h expected=%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: a read is described only by how many edges have passed since acceptance.
    logic          m_act  [2];
    int            m_t    [2];
    logic          m_chip [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_act[k]  <= 1'b0;
                m_t[k]    <= 0;
                m_chip[k] <= 1'b0;
                m_addr[k] <= '0;
                m_data[k] <= '0;
            end else if (!m_act[k]) begin
                if (rv[k]) begin
                    m_act[k]  <= 1'b1;
                    m_t[k]    <= 0;
                    m_chip[k] <= sc[k];
                    m_addr[k] <= sc[k] ? (ra[k] & 10'h1FF) : (ra[k] & 10'h0FF);
                end
            end else begin
                m_t[k] <= m_t[k] + 1;
                if (m_t[k] + 1 == s_of(k) + a_of(k))
                    m_data[k] <= m_chip[k] ? cd[k] : {4'b0000, cd[k][3:0]};
                if (m_t[k] + 1 == s_of(k) + a_of(k) + h_of(k))
                    m_act[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, bsy[k], m_act[k]);
                chk("req_ready", k, rdy[k], !m_act[k]);
                chk("chip_address_port", k, ca[k], m_addr[k]);
                chk("chip_selection_port", k, cs[k],
                    (m_act[k] && m_t[k] >= s_of(k) && m_t[k] < s_of(k) + a_of(k)) ?
                    (m_chip[k] ? 4'b1101 : 4'b1110) : 4'b1111);
                chk("rsp_valid", k, rsv[k], m_act[k] && m_t[k] == s_of(k) + a_of(k));
                chk("rsp_data", k, rd[k], m_data[k]);
            end
        end
    end

    task automatic run_read(input int k, input logic chip, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, output logic [AW-1:0] addr0,
                            output logic [3:0] sel_seen, output int first_sel, output int nsel,
                            output int rsp_e, output int rdy_e, output logic [DW-1:0] rdat);
        @(negedge clk);
        sc[k] = chip; ra[k] = addr; cd[k] = data; rv[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv[k] = 1'b0;
        addr0 = ca[k];
        first_sel = -1; nsel = 0; rsp_e = -1; rdy_e = -1; sel_seen = 4'hF; rdat = '0;
        for (int e = 1; e <= 40 && rdy_e < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1) begin
                ra[k] = ~addr;
                sc[k] = ~chip;
            end
            if (cs[k] != 4'hF) begin
                if (first_sel < 0) first_sel = e;
                sel_seen = cs[k];
                nsel++;
            end
            if (rsv[k]) begin
                rsp_e = e;
                rdat  = rd[k];
            end
            if (rdy[k]) rdy_e = e;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a0;
        logic [3:0]    sel;
        logic [DW-1:0] rdat;
        int fs, ns, re, ye;
        int acc [4];
        int rsp [4];
        int nacc, nrsp;

        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; sc[k] = 1'b0; ra[k] = '0; cd[k] = '0;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_en = 1'b1;

        // Idle after reset
        @(negedge clk);
        chk("idle_sel", 0, cs[0], 4'b1111);
        chk("idle_ready", 0, rdy[0], 1'b1);
        chk("idle_busy", 0, bsy[0], 1'b0);
        chk("idle_rsp_valid", 0, rsv[0], 1'b0);
        chk("idle_addr", 0, ca[0], 10'h000);

        // IP3604 read with default timing
        run_read(0, 1'b1, 10'h1A5, 8'h3C, a0, sel, fs, ns, re, ye, rdat);
        chk("t2_addr", 0, a0, 10'h1A5);
        chk("t2_sel_value", 0, sel, 4'b1101);
        chk("t2_sel_first_edge", 0, fs, 2);
        chk("t2_sel_cycles", 0, ns, 8);
        chk("t2_rsp_edge", 0, re, 10);
        chk("t2_rsp_data", 0, rdat, 8'h3C);
        chk("t2_ready_edge", 0, ye, 11);

        // IP3601 read: address and data masking
        run_read(0, 1'b0, 10'h3FF, 8'hA7, a0, sel, fs, ns, re, ye, rdat);
        chk("t3_addr", 0, a0, 10'h0FF);
        chk("t3_sel_value", 0, sel, 4'b1110);
        chk("t3_sel_cycles", 0, ns, 8);
        chk("t3_rsp_data", 0, rdat, 8'h07);

        // Back-to-back with req_valid held high
        @(negedge clk);
        sc[0] = 1'b1; ra[0] = 10'h000; cd[0] = 8'h11; rv[0] = 1'b1;
        nacc = 0; nrsp = 0;
        for (int e = 1; e <= 30; e++) begin
            if (rv[0] && rdy[0] && nacc < 4) begin
                acc[nacc] = e;
                nacc++;
            end
            @(posedge clk);
            @(negedge clk);
            if (nacc == 1) ra[0] = 10'h001;
            if (nacc == 2) rv[0] = 1'b0;
            if (nacc == 1 && e == 5) sc[0] = 1'b0;
            if (e == 8) sc[0] = 1'b1;
            if (rsv[0] && nrsp < 4) begin
                rsp[nrsp] = e;
                nrsp++;
            end
        end
        rv[0] = 1'b0;
        chk("t4_accept_count", 0, nacc, 2);
        chk("t4_rsp_count", 0, nrsp, 2);
        if (nacc == 2) chk("t4_accept_spacing", 0, acc[1] - acc[0], 12);
        if (nrsp == 2) chk("t4_rsp_spacing", 0, rsp[1] - rsp[0], 12);
        if (nacc >= 1 && nrsp >= 1) chk("t4_first_latency", 0, rsp[0] - acc[0], 10);

        // Reset during the fourth ACCESS cycle
        @(negedge clk);
        sc[0] = 1'b1; ra[0] = 10'h155; cd[0] = 8'hC3; rv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_sel_before_reset", 0, cs[0], 4'b1101);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_sel_async", 0, cs[0], 4'b1111);
        chk("t5_rsp_valid", 0, rsv[0], 1'b0);
        chk("t5_busy", 0, bsy[0], 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        run_read(0, 1'b1, 10'h0AA, 8'h5A, a0, sel, fs, ns, re, ye, rdat);
        chk("t5_after_addr", 0, a0, 10'h0AA);
        chk("t5_after_rsp_edge", 0, re, 10);
        chk("t5_after_rsp_data", 0, rdat, 8'h5A);

        // Minimum timing instance
        run_read(1, 1'b1, 10'h2C3, 8'h96, a0, sel, fs, ns, re, ye, rdat);
        chk("t6_addr", 1, a0, 10'h0C3);
        chk("t6_sel_first_edge", 1, fs, 1);
        chk("t6_sel_cycles", 1, ns, 1);
        chk("t6_rsp_edge", 1, re, 2);
        chk("t6_ready_edge", 1, ye, 3);
        chk("t6_rsp_data", 1, rdat, 8'h96);

        repeat (3) @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_access_controller.md
Name: rom_access_controller

Overview:
- Sequences physical read cycles on the shared ROM socket bus (address, chip-select, data) for the two supported chips: IP3601 (256x4) and IP3604 (512x8).
- Sits between the address-stepping logic (button-driven increment/decrement) and the chip pins.
- Applies the selected chip's address/data width masking and the setup/access/hold timing.
- Returns one registered data word per accepted request.

Parameters:
- ADDRESS_WIDTH, 10, width of chip_address_port and req_address
- DATA_WIDTH, 8, width of chip_data_port and rsp_data
- SETUP_CYCLES, 2, cycles the address is stable before chip-select asserts (>=1)
- ACCESS_CYCLES, 8, cycles chip-select is asserted before data is sampled (>=1)
- HOLD_CYCLES, 1, cycles the address is held after chip-select deasserts (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- selected_chip  in  1  0 = IP3601, 1 = IP3604; sampled only at request acceptance
- req_valid  in  1  read request
- req_ready  out  1  high only in IDLE
- req_address  in  ADDRESS_WIDTH  requested ROM address
- rsp_valid  out  1  one-cycle pulse; rsp_data valid
- rsp_data  out  DATA_WIDTH  registered read data
- busy  out  1  high in any state other than IDLE
- chip_address_port  out  ADDRESS_WIDTH  registered address to socket
- chip_selection_port  out  4  active-low selects; idle 4'b1111
- chip_data_port  in  DATA_WIDTH  data from socket

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low (reset_n).
- Reset values: FSM = IDLE, chip_address_port = 0, chip_selection_port = 4'b1111, rsp_valid = 0, rsp_data = 0, busy = 0, counter = 0.
- Request acceptance: on an edge with req_valid & req_ready, latch the chip, the masked address and load the counter.
- Address masking:
  - IP3601: address[7:0]; upper bits driven 0.
  - IP3604: address[8:0]; upper bits driven 0.
- FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
  - SETUP: address driven, selects 4'b1111, lasts SETUP_CYCLES.
  - ACCESS: select asserted for ACCESS_CYCLES. IP3601 drives 4'b1110; IP3604 drives 4'b1101. Bits [3:2] always 1.
  - At the final ACCESS edge: sample chip_data_port into rsp_data, pulse rsp_valid for 1 cycle, deassert selects and enter HOLD. For IP3601, rsp_data = {4'b0, chip_data_port[3:0]}.
  - HOLD: address held, selects 4'b1111, lasts HOLD_CYCLES. Then IDLE; chip_address_port keeps its last value.
- Latency:
  - rsp_valid goes high SETUP_CYCLES+ACCESS_CYCLES edges after the acceptance edge.
  - req_ready returns after SETUP+ACCESS+HOLD edges.
  - Minimum request spacing = SETUP+ACCESS+HOLD+1 cycles.
- Counter: a single down-counter sized $clog2(max(SETUP,ACCESS,HOLD)+1), reloaded on each state entry.
- Request rules:
  - req_valid while busy is ignored and not queued. The requester holds req_valid until it sees req_ready.
  - Changes to req_address and selected_chip mid-access have no effect.
- rsp_data holds its value until the next sample.
- Reset mid-access: selects return to 4'b1111 immediately (asynchronous), no rsp_valid, FSM = IDLE.
- Chip-select glitch rule: select lines change only on FSM transitions (registered outputs). The select never asserts in the same cycle the address changes.

Test Plan:
1. Reset, then idle → chip_selection_port=4'b1111, req_ready=1, busy=0, rsp_valid=0, chip_address_port=0.
2. IP3604 read, defaults, req_address=10'h1A5, chip_data_port=8'h3C:
   - chip_address_port=10'h1A5 from edge 1.
   - selects=4'b1101 for exactly 8 cycles starting edge 2.
   - rsp_valid pulse after edge 10 with rsp_data=8'h3C.
   - req_ready back after edge 11.
3. IP3601 read, req_address=10'h3FF, chip_data_port=8'hA7 → chip_address_port=10'h0FF, selects=4'b1110, rsp_data=8'h07.
4. Back-to-back: req_valid held high with addresses 0 then 1 → second acceptance exactly 12 cycles after the first; no overlap of select assertion; two rsp_valid pulses 12 cycles apart. Toggling selected_chip mid-access does not change selects.
5. Assert reset_n=0 during ACCESS cycle 4 → selects=4'b1111 immediately, no rsp_valid. After release, a new request completes normally.
6. Parameters SETUP=1, ACCESS=1, HOLD=1 → rsp_valid 2 edges after acceptance; req_ready 3 edges after acceptance.
